// File: rtl/axi4_pkg.sv
// Shared AXI4 burst types, response codes and the per-beat address step.
package axi4_pkg;
    typedef enum logic [1:0] {
        FIXED = 2'd0,
        INCR  = 2'd1,
        WRAP  = 2'd2
    } burst_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    // Computed at 64 bits; callers truncate to their own address width.
    function automatic logic [63:0] next_addr(
        input logic [63:0] addr,
        input logic [2:0]  size,
        input logic [7:0]  len,
        input logic [1:0]  burst
    );
        logic [63:0] beat_bytes;
        logic [63:0] win_mask;
        beat_bytes = 64'd1 << size;
        win_mask   = ((64'(len) + 64'd1) << size) - 64'd1;
        case (burst_t'(burst))
            FIXED:   next_addr = addr;
            WRAP:    next_addr = (addr & ~win_mask) | ((addr + beat_bytes) & win_mask);
            default: next_addr = addr + beat_bytes;
        endcase
    endfunction
endpackage

// File: rtl/axi4_burst_addr.sv
// Burst tracker for one engine: latches the request, steps the address per beat
// and flags bursts that the memory cannot legally serve.
module axi4_burst_addr
    import axi4_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              adv,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [7:0]        start_len,
    input  logic [2:0]        start_size,
    input  logic [1:0]        start_burst,
    output logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] addr_nxt,
    output logic              last,
    output logic              last_nxt,
    output logic              err,
    output logic              err_start
);
    localparam int          OFF_W     = $clog2(DATA_W / 8);
    localparam logic [63:0] MEM_BYTES = 64'(DEPTH) * 64'(DATA_W / 8);

    logic [7:0] len_q;
    logic [7:0] cnt_q;
    logic [2:0] size_q;
    logic [1:0] burst_q;

    always_comb begin
        err_start = 1'b0;
        if (64'(start_addr) >= MEM_BYTES)
            err_start = 1'b1;
        if (start_size > 3'(OFF_W))
            err_start = 1'b1;
        if (start_burst == 2'b11)
            err_start = 1'b1;
        if (start_burst == WRAP && start_len != 8'd1 && start_len != 8'd3 &&
            start_len != 8'd7 && start_len != 8'd15)
            err_start = 1'b1;
    end

    assign addr_nxt = ADDR_W'(next_addr(64'(addr), size_q, len_q, burst_q));
    assign last     = (cnt_q == len_q);
    assign last_nxt = ((cnt_q + 8'd1) == len_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr    <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            err     <= 1'b0;
        end else if (load) begin
            addr    <= start_addr;
            len_q   <= start_len;
            cnt_q   <= '0;
            size_q  <= start_size;
            burst_q <= start_burst;
            err     <= err_start;
        end else if (adv) begin
            addr  <= addr_nxt;
            cnt_q <= cnt_q + 8'd1;
        end
    end
endmodule

// File: rtl/axi4_mem_slave.sv
// AXI4 memory endpoint with independent write and read engines over a word array.
//
// state    | meaning
// WA_IDLE  | AWREADY high, waiting for a write request
// WA_DATA  | WREADY high, committing write beats
// WA_RESP  | BVALID high, holding the write response
// RA_IDLE  | ARREADY high, waiting for a read request
// RA_DATA  | RVALID high, presenting read beats
module axi4_mem_slave
    import axi4_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4,
    parameter int DEPTH  = 1024
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic                AWVALID,
    output logic                AWREADY,
    input  logic [ID_W-1:0]     AWID,
    input  logic [ADDR_W-1:0]   AWADDR,
    input  logic [7:0]          AWLEN,
    input  logic [2:0]          AWSIZE,
    input  logic [1:0]          AWBURST,
    input  logic                WVALID,
    output logic                WREADY,
    input  logic [DATA_W-1:0]   WDATA,
    input  logic [DATA_W/8-1:0] WSTRB,
    input  logic                WLAST,
    output logic                BVALID,
    output logic [ID_W-1:0]     BID,
    output logic [1:0]          BRESP,
    input  logic                BREADY,
    input  logic                ARVALID,
    output logic                ARREADY,
    input  logic [ID_W-1:0]     ARID,
    input  logic [ADDR_W-1:0]   ARADDR,
    input  logic [7:0]          ARLEN,
    input  logic [2:0]          ARSIZE,
    input  logic [1:0]          ARBURST,
    output logic                RVALID,
    output logic [ID_W-1:0]     RID,
    output logic [DATA_W-1:0]   RDATA,
    output logic [1:0]          RRESP,
    output logic                RLAST,
    input  logic                RREADY
);
    localparam int OFF_W = $clog2(DATA_W / 8);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] { WA_IDLE, WA_DATA, WA_RESP } wr_state_t;
    typedef enum logic       { RA_IDLE, RA_DATA }          rd_state_t;

    wr_state_t wr_state;
    rd_state_t rd_state;

    logic [DATA_W-1:0] mem [DEPTH];

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic wlast_err;

    logic [ADDR_W-1:0] wr_addr, wr_addr_nxt, rd_addr, rd_addr_nxt;
    logic              wr_last, wr_last_nxt, wr_err, wr_err_start;
    logic              rd_last, rd_last_nxt, rd_err, rd_err_start;
    logic [IDX_W-1:0]  wr_idx, rd_idx0, rd_idx_nxt;

    assign aw_hs = AWVALID & AWREADY;
    assign w_hs  = WVALID & WREADY;
    assign b_hs  = BVALID & BREADY;
    assign ar_hs = ARVALID & ARREADY;
    assign r_hs  = RVALID & RREADY;

    axi4_burst_addr #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_wr_addr (
        .clk         (ACLK),
        .rst_n       (ARESETn),
        .load        (aw_hs),
        .adv         (w_hs),
        .start_addr  (AWADDR),
        .start_len   (AWLEN),
        .start_size  (AWSIZE),
        .start_burst (AWBURST),
        .addr        (wr_addr),
        .addr_nxt    (wr_addr_nxt),
        .last        (wr_last),
        .last_nxt    (wr_last_nxt),
        .err         (wr_err),
        .err_start   (wr_err_start)
    );

    axi4_burst_addr #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_rd_addr (
        .clk         (ACLK),
        .rst_n       (ARESETn),
        .load        (ar_hs),
        .adv         (r_hs),
        .start_addr  (ARADDR),
        .start_len   (ARLEN),
        .start_size  (ARSIZE),
        .start_burst (ARBURST),
        .addr        (rd_addr),
        .addr_nxt    (rd_addr_nxt),
        .last        (rd_last),
        .last_nxt    (rd_last_nxt),
        .err         (rd_err),
        .err_start   (rd_err_start)
    );

    // Index bits only; addresses past the array wrap modulo DEPTH.
    assign wr_idx     = wr_addr[IDX_W+OFF_W-1:OFF_W];
    assign rd_idx0    = ARADDR[IDX_W+OFF_W-1:OFF_W];
    assign rd_idx_nxt = rd_addr_nxt[IDX_W+OFF_W-1:OFF_W];

    logic unused_ok;
    assign unused_ok = ^{wr_addr_nxt, wr_last_nxt, wr_err_start, rd_addr, rd_last,
                         wr_addr[ADDR_W-1:IDX_W+OFF_W], wr_addr[OFF_W-1:0],
                         rd_addr_nxt[ADDR_W-1:IDX_W+OFF_W], rd_addr_nxt[OFF_W-1:0]};

    always_ff @(posedge ACLK) begin
        if (w_hs && !wr_err) begin
            for (int b = 0; b < DATA_W / 8; b++) begin
                if (WSTRB[b])
                    mem[wr_idx][8*b +: 8] <= WDATA[8*b +: 8];
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_state  <= WA_IDLE;
            AWREADY   <= 1'b0;
            WREADY    <= 1'b0;
            BVALID    <= 1'b0;
            BID       <= '0;
            BRESP     <= OKAY;
            wlast_err <= 1'b0;
        end else begin
            case (wr_state)
                WA_IDLE: begin
                    AWREADY <= 1'b1;
                    if (aw_hs) begin
                        AWREADY   <= 1'b0;
                        WREADY    <= 1'b1;
                        BID       <= AWID;
                        wlast_err <= 1'b0;
                        wr_state  <= WA_DATA;
                    end
                end
                WA_DATA: begin
                    if (w_hs) begin
                        if (WLAST != wr_last)
                            wlast_err <= 1'b1;
                        // The beat count, not WLAST, ends the burst.
                        if (wr_last) begin
                            WREADY   <= 1'b0;
                            BVALID   <= 1'b1;
                            BRESP    <= (wr_err || wlast_err || (WLAST != wr_last)) ? SLVERR : OKAY;
                            wr_state <= WA_RESP;
                        end
                    end
                end
                WA_RESP: begin
                    if (b_hs) begin
                        BVALID   <= 1'b0;
                        AWREADY  <= 1'b1;
                        wr_state <= WA_IDLE;
                    end
                end
                default: wr_state <= WA_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rd_state <= RA_IDLE;
            ARREADY  <= 1'b0;
            RVALID   <= 1'b0;
            RID      <= '0;
            RDATA    <= '0;
            RRESP    <= OKAY;
            RLAST    <= 1'b0;
        end else begin
            case (rd_state)
                RA_IDLE: begin
                    ARREADY <= 1'b1;
                    if (ar_hs) begin
                        ARREADY  <= 1'b0;
                        RVALID   <= 1'b1;
                        RID      <= ARID;
                        RLAST    <= (ARLEN == 8'd0);
                        RRESP    <= rd_err_start ? SLVERR : OKAY;
                        RDATA    <= rd_err_start ? '0 : mem[rd_idx0];
                        rd_state <= RA_DATA;
                    end
                end
                RA_DATA: begin
                    if (r_hs) begin
                        if (RLAST) begin
                            RVALID   <= 1'b0;
                            RLAST    <= 1'b0;
                            ARREADY  <= 1'b1;
                            rd_state <= RA_IDLE;
                        end else begin
                            RLAST <= rd_last_nxt;
                            RDATA <= rd_err ? '0 : mem[rd_idx_nxt];
                        end
                    end
                end
                default: rd_state <= RA_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi4_mem_slave.sv
// Directed bench for axi4_mem_slave: hand-computed expectations, immediate assertions.
module tb_axi4_mem_slave;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int ID_W   = 4;
    localparam int DEPTH  = 1024;

    logic              ACLK = 1'b0;
    logic              ARESETn = 1'b0;
    logic              AWVALID = 1'b0, AWREADY;
    logic [ID_W-1:0]   AWID = '0;
    logic [ADDR_W-1:0] AWADDR = '0;
    logic [7:0]        AWLEN = '0;
    logic [2:0]        AWSIZE = 3'd2;
    logic [1:0]        AWBURST = 2'd1;
    logic              WVALID = 1'b0, WREADY;
    logic [DATA_W-1:0] WDATA = '0;
    logic [3:0]        WSTRB = '0;
    logic              WLAST = 1'b0;
    logic              BVALID;
    logic [ID_W-1:0]   BID;
    logic [1:0]        BRESP;
    logic              BREADY = 1'b0;
    logic              ARVALID = 1'b0, ARREADY;
    logic [ID_W-1:0]   ARID = '0;
    logic [ADDR_W-1:0] ARADDR = '0;
    logic [7:0]        ARLEN = '0;
    logic [2:0]        ARSIZE = 3'd2;
    logic [1:0]        ARBURST = 2'd1;
    logic              RVALID;
    logic [ID_W-1:0]   RID;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RLAST;
    logic              RREADY = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    axi4_mem_slave #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .DEPTH(DEPTH)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWID(AWID), .AWADDR(AWADDR),
        .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
        .BVALID(BVALID), .BID(BID), .BRESP(BRESP), .BREADY(BREADY),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARID(ARID), .ARADDR(ARADDR),
        .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .RVALID(RVALID), .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_aw(input logic [3:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [1:0] burst);
        logic got;
        got = 1'b0;
        AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = 3'd2; AWBURST = burst; AWVALID = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            got = AWREADY;
            step();
        end
        AWVALID = 1'b0;
        chk("aw_handshake", 64'(got), 64'(1));
        chk("aw_to_data", 64'({AWREADY, WREADY}), 64'(2'b01));
    endtask

    task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last);
        logic got;
        got = 1'b0;
        WDATA = data; WSTRB = strb; WLAST = last; WVALID = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            got = WREADY;
            step();
        end
        WVALID = 1'b0; WLAST = 1'b0;
        chk("w_handshake", 64'(got), 64'(1));
    endtask

    task automatic wait_b(input logic [3:0] id, input logic [1:0] resp, input int hold);
        BREADY = 1'b0;
        chk("w_to_resp", 64'({WREADY, BVALID}), 64'(2'b01));
        for (int i = 0; i < 20 && !BVALID; i++) step();
        chk("b_payload", 64'({BVALID, BID, BRESP}), 64'({1'b1, id, resp}));
        for (int i = 0; i < hold; i++) begin
            step();
            chk("b_hold", 64'({BVALID, BID, BRESP}), 64'({1'b1, id, resp}));
        end
        BREADY = 1'b1;
        step();
        BREADY = 1'b0;
        chk("b_done", 64'({BVALID, AWREADY}), 64'(2'b01));
    endtask

    task automatic do_ar(input logic [3:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [1:0] burst);
        logic got;
        got = 1'b0;
        ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = 3'd2; ARBURST = burst; ARVALID = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            got = ARREADY;
            step();
        end
        ARVALID = 1'b0;
        chk("ar_handshake", 64'(got), 64'(1));
        chk("ar_to_data", 64'({ARREADY, RVALID}), 64'(2'b01));
    endtask

    task automatic r_beat(input logic [3:0] id, input logic [31:0] data,
                          input logic [1:0] resp, input logic last);
        RREADY = 1'b1;
        for (int i = 0; i < 20 && !RVALID; i++) step();
        chk("r_payload", 64'({RVALID, RID, RRESP, RLAST, RDATA}), 64'({1'b1, id, resp, last, data}));
        step();
    endtask

    task automatic r_end();
        RREADY = 1'b0;
        chk("r_done", 64'({RVALID, ARREADY}), 64'(2'b01));
    endtask

    task automatic chk_reset_outs(input string tag);
        chk(tag, 64'({AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST}), 64'(0));
        chk({tag, "_payload"}, 64'({BID, BRESP, RID, RRESP, RDATA}), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, then ready lines rise one edge after release.
        step(); step();
        chk_reset_outs("reset");
        ARESETn = 1'b1;
        chk("ready_before_edge", 64'({AWREADY, ARREADY}), 64'(2'b00));
        step();
        chk("ready_after_release", 64'({AWREADY, ARREADY}), 64'(2'b11));

        // INCR write 0x10..0x1C, then INCR readback.
        do_aw(4'd3, 32'h10, 8'd3, 2'd1);
        w_beat(32'hA0, 4'hF, 1'b0);
        w_beat(32'hA1, 4'hF, 1'b0);
        w_beat(32'hA2, 4'hF, 1'b0);
        w_beat(32'hA3, 4'hF, 1'b1);
        wait_b(4'd3, 2'b00, 0);

        do_ar(4'd5, 32'h10, 8'd3, 2'd1);
        r_beat(4'd5, 32'hA0, 2'b00, 1'b0);
        r_beat(4'd5, 32'hA1, 2'b00, 1'b0);
        r_beat(4'd5, 32'hA2, 2'b00, 1'b0);
        r_beat(4'd5, 32'hA3, 2'b00, 1'b1);
        r_end();

        // WRAP from 0x18: 0x18, 0x1C, 0x10, 0x14.
        do_ar(4'd6, 32'h18, 8'd3, 2'd2);
        r_beat(4'd6, 32'hA2, 2'b00, 1'b0);
        r_beat(4'd6, 32'hA3, 2'b00, 1'b0);
        r_beat(4'd6, 32'hA0, 2'b00, 1'b0);
        r_beat(4'd6, 32'hA1, 2'b00, 1'b1);
        r_end();

        // WRAP with LEN=2 is illegal: three SLVERR beats with zero data.
        do_ar(4'd7, 32'h18, 8'd2, 2'd2);
        r_beat(4'd7, 32'h0, 2'b10, 1'b0);
        r_beat(4'd7, 32'h0, 2'b10, 1'b0);
        r_beat(4'd7, 32'h0, 2'b10, 1'b1);
        r_end();

        // Byte strobes: lanes 0 and 2 overwritten.
        do_aw(4'd1, 32'h40, 8'd0, 2'd1);
        w_beat(32'h12345678, 4'hF, 1'b1);
        wait_b(4'd1, 2'b00, 0);
        do_aw(4'd2, 32'h40, 8'd0, 2'd1);
        w_beat(32'hFFFFFFFF, 4'b0101, 1'b1);
        wait_b(4'd2, 2'b00, 0);
        do_ar(4'd2, 32'h40, 8'd0, 2'd1);
        r_beat(4'd2, 32'h12FF56FF, 2'b00, 1'b1);
        r_end();

        // Out-of-range write aliases word 0 by index but must not land.
        do_aw(4'd4, 32'h0, 8'd0, 2'd1);
        w_beat(32'h11111111, 4'hF, 1'b1);
        wait_b(4'd4, 2'b00, 0);
        do_aw(4'd8, 32'h1000, 8'd0, 2'd1);
        w_beat(32'hDEADBEEF, 4'hF, 1'b1);
        wait_b(4'd8, 2'b10, 0);
        do_ar(4'd8, 32'h0, 8'd0, 2'd1);
        r_beat(4'd8, 32'h11111111, 2'b00, 1'b1);
        r_end();

        // INCR from the last word rolls over to word 0.
        do_aw(4'd9, 32'hFFC, 8'd1, 2'd1);
        w_beat(32'hC0, 4'hF, 1'b0);
        w_beat(32'hC1, 4'hF, 1'b1);
        wait_b(4'd9, 2'b00, 0);
        do_ar(4'd9, 32'hFFC, 8'd1, 2'd1);
        r_beat(4'd9, 32'hC0, 2'b00, 1'b0);
        r_beat(4'd9, 32'hC1, 2'b00, 1'b1);
        r_end();

        // Early WLAST: all four beats still taken, BRESP=SLVERR, BREADY stalled 5 cycles.
        do_aw(4'hA, 32'h20, 8'd3, 2'd1);
        w_beat(32'hB0, 4'hF, 1'b0);
        w_beat(32'hB1, 4'hF, 1'b1);
        w_beat(32'hB2, 4'hF, 1'b0);
        w_beat(32'hB3, 4'hF, 1'b0);
        wait_b(4'hA, 2'b10, 5);

        // Readback with RREADY stalled for three cycles on beat 1.
        do_ar(4'hB, 32'h20, 8'd3, 2'd1);
        r_beat(4'hB, 32'hB0, 2'b00, 1'b0);
        RREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("r_stall_hold", 64'({RVALID, RLAST, RDATA}), 64'({1'b1, 1'b0, 32'hB1}));
        end
        r_beat(4'hB, 32'hB1, 2'b00, 1'b0);
        r_beat(4'hB, 32'hB2, 2'b00, 1'b0);
        r_beat(4'hB, 32'hB3, 2'b00, 1'b1);
        r_end();

        // Reset mid write burst, then a fresh burst after release.
        do_aw(4'hC, 32'h30, 8'd3, 2'd1);
        w_beat(32'hE0, 4'hF, 1'b0);
        w_beat(32'hE1, 4'hF, 1'b0);
        ARESETn = 1'b0;
        #1;
        chk_reset_outs("mid_reset");
        step(); step();
        ARESETn = 1'b1;
        step();
        chk("ready_after_reset", 64'({AWREADY, WREADY, ARREADY}), 64'(3'b101));
        do_aw(4'hD, 32'h30, 8'd0, 2'd1);
        w_beat(32'h77, 4'hF, 1'b1);
        wait_b(4'hD, 2'b00, 0);
        do_ar(4'hD, 32'h30, 8'd0, 2'd1);
        r_beat(4'hD, 32'h77, 2'b00, 1'b1);
        r_end();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/axi4_mem_slave.md
# axi4_mem_slave

Parametrised AXI4 memory slave with independent write and read engines that accept FIXED, INCR and WRAP bursts and back them with an internal word-addressed memory array. It is the successor to the single-channel AW handshake block: it handles all five channels completely, with burst address generation, byte strobes and error responses. It is an endpoint on the interconnect and serves as the bench target for master-side blocks.

## Interface
- DATA_W, 32: data bus width in bits; legal values are 32 and 64.
- ADDR_W, 32: address width in bits.
- ID_W, 4: transaction ID width in bits.
- DEPTH, 1024: memory depth in DATA_W words; must be a power of 2.
- ACLK  in  1  clock
- ARESETn  in  1  reset; one clock, asynchronous, active-low
- AWVALID/AWREADY  in/out  1  write address handshake
- AWID  in  ID_W; AWADDR  in  ADDR_W; AWLEN  in  8; AWSIZE  in  3; AWBURST  in  2
- WVALID/WREADY  in/out  1; WDATA  in  DATA_W; WSTRB  in  DATA_W/8; WLAST  in  1
- BVALID  out  1; BID  out  ID_W; BRESP  out  2; BREADY  in  1
- ARVALID/ARREADY  in/out  1; ARID  in  ID_W; ARADDR  in  ADDR_W; ARLEN  in  8; ARSIZE  in  3; ARBURST  in  2
- RVALID  out  1; RID  out  ID_W; RDATA  out  DATA_W; RRESP  out  2; RLAST  out  1; RREADY  in  1

## Operation
- Write FSM has three states: WA_IDLE (AWREADY=1), WA_DATA (WREADY=1) and WA_RESP (BVALID=1).
  - AW handshake: latch ID, address, length, size and burst type, then go to WA_DATA.
  - Each W handshake commits WDATA byte lanes where WSTRB=1, then advances the address and beat count.
  - After the beat with count==AWLEN, go to WA_RESP.
  - On B handshake, return to WA_IDLE.
- Read FSM has two states: RA_IDLE (ARREADY=1) and RA_DATA (RVALID=1).
  - AR handshake: latch the request and load beat 0.
  - Each R handshake loads the next beat.
  - The handshake with RLAST=1 returns the FSM to RA_IDLE.
- Address update per beat:
  - FIXED: address is held.
  - INCR: address += 2^SIZE.
  - WRAP: address += 2^SIZE, wrapped within the aligned (LEN+1)*2^SIZE window.
- Memory index is addr[log2(DEPTH)+log2(DATA_W/8)-1 : log2(DATA_W/8)]. Sub-word transfers use WSTRB only; the slave does not lane-mask.
- Error checks, all giving SLVERR (2'b10):
  - Start address at or above DEPTH*DATA_W/8.
  - SIZE > log2(DATA_W/8).
  - WRAP with LEN not in {1,3,7,15}.
  - Burst type 2'b11.
- Error bursts still run their full beat count. Writes are dropped and reads return RDATA=0 with RRESP=SLVERR on every beat.
- The slave ends a write burst on its own beat count. If WLAST is mismatched on any beat, BRESP=SLVERR, but the data is still written.
- Otherwise responses are OKAY (2'b00).
- Read and write engines run concurrently. A write committed at edge N is visible to a read beat loaded at edge N+1 or later, but not to one loaded at edge N.

## Timing
- All outputs are registered.
- While ARESETn=0:
  - AWREADY, WREADY, BVALID, ARREADY, RVALID and RLAST are 0.
  - BID, BRESP, RID, RRESP and RDATA are 0.
  - Both FSMs are held in IDLE.
- AWREADY and ARREADY rise at the first edge after reset release.
- Write path latency:
  - AW handshake at edge N: AWREADY=0 and WREADY=1 from N+1.
  - Final W beat at edge M: WREADY=0 and BVALID=1 from M+1.
  - B handshake at edge K: BVALID=0 and AWREADY=1 from K+1.
- Read path latency:
  - AR handshake at edge N: RVALID=1 with beat 0 from N+1.
  - Beats are back-to-back while RREADY=1. ARREADY=1 again from the edge after the last R handshake.
- VALID outputs and their payload stay stable until the handshake completes; RREADY/BREADY low stalls indefinitely.
- Simultaneous AW and AR handshakes in the same cycle are both accepted.
- Reset mid-burst aborts the burst immediately. Memory contents are not reset.
- Address arithmetic is done at ADDR_W width. INCR past the end of memory wraps modulo DEPTH, with no error.

## Structure
- Package axi4_pkg holds:
  - The burst_t enum: FIXED=0, INCR=1, WRAP=2.
  - Response constants: OKAY=2'b00, SLVERR=2'b10.
  - The function next_addr(addr, size, len, burst).
- Sub-module axi4_burst_addr holds the latched address, beat counter, last flag and error flag. It is instantiated once for the write engine and once for the read engine.
- The memory is a reg array in the top module.

## Test plan
- INCR write, AWADDR=0x10, LEN=3, SIZE=2, data 0xA0..0xA3 -> BRESP=OKAY, BID=AWID. INCR read of the same region returns 0xA0..0xA3, with RLAST only on the 4th beat and RVALID at AR+1.
- WRAP read, ARADDR=0x18, LEN=3, SIZE=2 -> addresses 0x18, 0x1C, 0x10, 0x14. LEN=2 -> SLVERR on all 3 beats and RDATA=0.
- Write WSTRB=4'b0101 with WDATA=0xFFFFFFFF over 0x12345678 -> readback 0x12FF56FF.
- AWADDR=DEPTH*4 (out of range) -> BRESP=SLVERR and the memory is unchanged. WLAST asserted on beat 1 of LEN=3 -> all 4 beats accepted and BRESP=SLVERR.
- RREADY toggled 1-0-1 during a burst and BREADY held low 5 cycles -> payloads stable, no beat lost or duplicated.
- ARESETn pulsed low mid write burst -> all outputs 0 immediately. AWREADY=1 at the edge after release, and a new burst completes OKAY.
